// File: rtl/mnist_seq_ctrl_if.sv
// Control/data bundle between the host side and the MNIST sequencer.
// The sequencer uses the slave view. The host/CPU side, or a bench, uses the master view.
interface mnist_seq_ctrl_if #(
    parameter int unsigned N_CLASS = 10,
    parameter int unsigned ACC_W   = 32
);
    logic                       start;
    logic                       abort;
    logic [N_CLASS*ACC_W-1:0]   results;
    logic [31:0]                pix_addr;
    logic                       acc_clr;
    logic                       mac_en;
    logic                       busy;
    logic                       done;
    logic [3:0]                 class_out;
    logic [ACC_W-1:0]           class_score;

    modport master (
        output start,
        output abort,
        output results,
        input  pix_addr,
        input  acc_clr,
        input  mac_en,
        input  busy,
        input  done,
        input  class_out,
        input  class_score
    );

    modport slave (
        input  start,
        input  abort,
        input  results,
        output pix_addr,
        output acc_clr,
        output mac_en,
        output busy,
        output done,
        output class_out,
        output class_score
    );
endinterface

// File: rtl/mnist_seq_ctrl.sv
// Sequencer for the MNIST inference datapath.
// A run has four phases:
//   1. Clear the accumulators.
//   2. Stream pixel addresses into xmem.
//   3. Raise mac_en in line with the memory read latency.
//   4. Run a signed argmax over the class accumulators and report the winner.
module mnist_seq_ctrl #(
    parameter int unsigned N_PIX   = 784,
    parameter int unsigned N_CLASS = 10,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned ACC_W   = 32
) (
    input logic             clk,
    input logic             reset,
    mnist_seq_ctrl_if.slave bus_io
);

    localparam int unsigned      AddrW      = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int unsigned      VldW       = MEM_LAT;
    localparam logic [AddrW-1:0] LastAddr   = AddrW'(N_PIX - 1);
    localparam logic [AddrW-1:0] PenultAddr = AddrW'((N_PIX > 1) ? (N_PIX - 2) : 0);
    localparam logic [2:0]       DrnLast    = 3'(MEM_LAT);
    localparam logic [3:0]       KLast      = 4'(N_CLASS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDrain,
        StArgmax,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [AddrW-1:0]         addr_q, addr_d;
    logic [2:0]               drn_q, drn_d;
    logic [VldW-1:0]          vld_q, vld_d;
    logic [3:0]               k_q, k_d;
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic [3:0]               idx_q, idx_d;
    logic [3:0]               cls_q, cls_d;
    logic signed [ACC_W-1:0]  score_q, score_d;

    logic                     issue;
    logic                     take;
    logic signed [ACC_W-1:0]  cur;

    // Next-state logic for the FSM, the address walk and the argmax scan.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drn_d   = drn_q;
        k_d     = k_q;
        max_d   = max_q;
        idx_d   = idx_q;
        cls_d   = cls_q;
        score_d = score_q;
        issue   = 1'b0;

        // Accumulator for the class currently being scanned.
        cur = '0;
        for (int i = 0; i < N_CLASS; i++) begin
            if (k_q == 4'(i)) begin
                cur = bus_io.results[i*ACC_W +: ACC_W];
            end
        end
        // Strict '>' so that the lower index wins a tie.
        take = (k_q == 4'd0) || (cur > max_q);

        unique case (state_q)
            StIdle: begin
                addr_d = '0;
                if (bus_io.start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                addr_d  = '0;
                drn_d   = '0;
                state_d = (N_PIX > 1) ? StFetch : StDrain;
            end
            StFetch: begin
                issue  = 1'b1;
                addr_d = addr_q + 1'b1;
                if (addr_q == PenultAddr) begin
                    drn_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The final address goes out on the first drain cycle.
                // The remaining MEM_LAT cycles flush the read pipeline.
                // The accumulators register their last MAC at the end of the drain.
                addr_d = LastAddr;
                issue  = (drn_q == 3'd0);
                drn_d  = drn_q + 3'd1;
                if (drn_q == DrnLast) begin
                    k_d     = 4'd0;
                    state_d = StArgmax;
                end
            end
            StArgmax: begin
                k_d = k_q + 4'd1;
                if (take) begin
                    max_d = cur;
                    idx_d = k_q;
                end
                if (k_q == KLast) begin
                    cls_d   = take ? k_q : idx_q;
                    score_d = take ? cur : max_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                addr_d  = '0;
                state_d = StIdle;
            end
            default: begin
                addr_d  = '0;
                state_d = StIdle;
            end
        endcase

        // abort overrides every transition, including a start seen in idle.
        if (bus_io.abort) begin
            state_d = StIdle;
            addr_d  = '0;
            issue   = 1'b0;
        end

        vld_d = bus_io.abort ? '0 : VldW'({vld_q, issue});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            drn_q   <= '0;
            vld_q   <= '0;
            k_q     <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            cls_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drn_q   <= drn_d;
            vld_q   <= vld_d;
            k_q     <= k_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            cls_q   <= cls_d;
            score_q <= score_d;
        end
    end

    assign bus_io.pix_addr    = 32'(addr_q);
    assign bus_io.acc_clr     = (state_q == StClear);
    assign bus_io.mac_en      = vld_q[VldW-1];
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.done        = (state_q == StDone);
    assign bus_io.class_out   = cls_q;
    assign bus_io.class_score = score_q;

endmodule

// File: tb/tb_mnist_seq_ctrl.sv
// Bench for mnist_seq_ctrl.
// Instance 0 uses the default parameters. Instance 1 uses N_PIX=4 and MEM_LAT=3.
// A timeline model predicts every output from the cycle count since the accepted start.
module tb_mnist_seq_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mnist_seq_ctrl_if #(.N_CLASS(10), .ACC_W(32)) bus_a ();
    mnist_seq_ctrl_if #(.N_CLASS(10), .ACC_W(32)) bus_b ();

    mnist_seq_ctrl #(.N_PIX(784), .N_CLASS(10), .MEM_LAT(1), .ACC_W(32)) u_dut_a (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_a)
    );

    mnist_seq_ctrl #(.N_PIX(4), .N_CLASS(10), .MEM_LAT(3), .ACC_W(32)) u_dut_b (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_b)
    );

    logic start_v [2];
    logic abort_v [2];
    assign bus_a.start = start_v[0];
    assign bus_a.abort = abort_v[0];
    assign bus_b.start = start_v[1];
    assign bus_b.abort = abort_v[1];

    logic        o_busy  [2];
    logic        o_clr   [2];
    logic        o_mac   [2];
    logic        o_done  [2];
    logic [31:0] o_pix   [2];
    logic [3:0]  o_cls   [2];
    logic [31:0] o_score [2];
    assign o_busy[0]  = bus_a.busy;
    assign o_busy[1]  = bus_b.busy;
    assign o_clr[0]   = bus_a.acc_clr;
    assign o_clr[1]   = bus_b.acc_clr;
    assign o_mac[0]   = bus_a.mac_en;
    assign o_mac[1]   = bus_b.mac_en;
    assign o_done[0]  = bus_a.done;
    assign o_done[1]  = bus_b.done;
    assign o_pix[0]   = bus_a.pix_addr;
    assign o_pix[1]   = bus_b.pix_addr;
    assign o_cls[0]   = bus_a.class_out;
    assign o_cls[1]   = bus_b.class_out;
    assign o_score[0] = bus_a.class_score;
    assign o_score[1] = bus_b.class_score;

    // Accelerator stand-in: xdata is all ones, so each MAC adds w[k].
    // results = accumulator + bias.
    int acc  [2][10];
    int w    [2][10];
    int bias [2][10];

    always_comb begin
        bus_a.results = '0;
        bus_b.results = '0;
        for (int k = 0; k < 10; k++) begin
            bus_a.results[k*32 +: 32] = acc[0][k] + bias[0][k];
            bus_b.results[k*32 +: 32] = acc[1][k] + bias[1][k];
        end
    end

    function automatic int np_of(input int i);
        return (i == 0) ? 784 : 4;
    endfunction

    function automatic int ml_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int dlat_of(input int i);
        return 1 + np_of(i) + ml_of(i) + 1 + 10;
    endfunction

    function automatic int res_of(input int i, input int k);
        return acc[i][k] + bias[i][k];
    endfunction

    function automatic int best_of(input int i);
        int b = 0;
        for (int k = 1; k < 10; k++) begin
            if (res_of(i, k) > res_of(i, b)) b = k;
        end
        return b;
    endfunction

    // Model state: active flag, cycles since the accepted start (d=1 is the clear cycle).
    bit m_act    [2];
    int m_d      [2];
    int m_cls    [2];
    int m_score  [2];
    int done_cnt [2];

    // Accelerator emulation and the model's timeline.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 10; k++) begin
                if (o_clr[i] === 1'b1) acc[i][k] <= 0;
                else if (o_mac[i] === 1'b1) acc[i][k] <= acc[i][k] + w[i][k];
            end
            if (o_done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
            if (reset) begin
                m_act[i]   <= 1'b0;
                m_d[i]     <= 0;
                m_cls[i]   <= 0;
                m_score[i] <= 0;
            end else if (m_act[i]) begin
                if (abort_v[i] || m_d[i] == dlat_of(i)) begin
                    m_act[i] <= 1'b0;
                end else begin
                    m_d[i] <= m_d[i] + 1;
                    if (m_d[i] + 1 == dlat_of(i)) begin
                        m_cls[i]   <= best_of(i);
                        m_score[i] <= res_of(i, best_of(i));
                    end
                end
            end else if (start_v[i] && !abort_v[i]) begin
                m_act[i] <= 1'b1;
                m_d[i]   <= 1;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] got=%0h exp=%0h t=%0t", nm, inst, got, exp, $time);
    endtask

    // One cycle.
    // At the negedge, every output of both instances is compared with the model.
    // The task then returns just after the next posedge.
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            int d;
            int np;
            int ml;
            bit a;
            int e_pix;
            d  = m_d[i];
            a  = m_act[i];
            np = np_of(i);
            ml = ml_of(i);
            e_pix = (a && d >= 2) ? ((d - 2 < np - 1) ? d - 2 : np - 1) : 0;
            chk("busy", i, 32'(o_busy[i]), 32'(a));
            chk("acc_clr", i, 32'(o_clr[i]), 32'(a && d == 1));
            chk("mac_en", i, 32'(o_mac[i]), 32'(a && d >= 2 + ml && d <= 1 + ml + np));
            chk("done", i, 32'(o_done[i]), 32'(a && d == dlat_of(i)));
            chk("pix_addr", i, o_pix[i], 32'(e_pix));
            chk("class_out", i, 32'(o_cls[i]), 32'(m_cls[i]));
            chk("class_score", i, o_score[i], 32'(m_score[i]));
        end
        @(posedge clk);
        #1;
    endtask

    // Start an inference on instance i and wait (bounded) until done is seen.
    // lat is the number of cycles from the start cycle to the done cycle.
    task automatic run(input int i, input bit hold, output int lat);
        start_v[i] = 1'b1;
        cyc();
        if (!hold) start_v[i] = 1'b0;
        lat = 1;
        while (o_done[i] !== 1'b1 && lat < 2000) begin
            cyc();
            lat++;
        end
        start_v[i] = 1'b0;
    endtask

    int lat;
    int dc0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                w[i][k]    = 0;
                bias[i][k] = 0;
            end
        end
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("rst_class", 1, 32'(o_cls[1]), 32'd0);

        // 1: weights 3,1,4,1,5,9,2,6,5,3 over 784 pixels -> class 5, 784*9=7056.
        w[0] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        run(0, 1'b0, lat);
        chk("t1_latency", 0, 32'(lat), 32'd797);
        chk("t1_class", 0, 32'(o_cls[0]), 32'd5);
        chk("t1_score", 0, o_score[0], 32'd7056);
        cyc();
        chk("t1_busy_after", 0, 32'(o_busy[0]), 32'd0);

        // 2: a tie between classes 1 and 2 resolves to the lower index.
        w[0]    = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bias[0] = '{-5, 7, 7, 3, -1, 0, 2, 1, 6, -100};
        run(0, 1'b0, lat);
        chk("t2_class", 0, 32'(o_cls[0]), 32'd1);
        chk("t2_score", 0, o_score[0], 32'd7);
        cyc();

        // 3: all results negative, so the compare must be signed.
        bias[0] = '{-10, -3, -7, -50, -8, -9, -4, -20, -6, -2};
        run(0, 1'b0, lat);
        chk("t3_class", 0, 32'(o_cls[0]), 32'd9);
        chk("t3_score", 0, o_score[0], -32'sd2);
        cyc();

        // start and abort in the same idle cycle: abort wins.
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        chk("start_abort_idle", 0, 32'(o_busy[0]), 32'd0);

        // 4: small instance, 4 pixels, weight k+1 -> class 9, score 4*10=40, done at T+19.
        w[1] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        run(1, 1'b0, lat);
        chk("t4_latency", 1, 32'(lat), 32'd19);
        chk("t4_class", 1, 32'(o_cls[1]), 32'd9);
        chk("t4_score", 1, o_score[1], 32'd40);
        cyc();

        // 5: abort in the 100th FETCH cycle (T+101), then a clean full run.
        w[0]    = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        bias[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        dc0 = done_cnt[0];
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (100) cyc();
        abort_v[0] = 1'b1;
        cyc();
        abort_v[0] = 1'b0;
        chk("t5_abort_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("t5_abort_pix", 0, o_pix[0], 32'd0);
        chk("t5_abort_class", 0, 32'(o_cls[0]), 32'd9);
        repeat (40) cyc();
        chk("t5_no_done", 0, 32'(done_cnt[0] - dc0), 32'd0);
        run(0, 1'b0, lat);
        chk("t5_latency", 0, 32'(lat), 32'd797);
        chk("t5_class", 0, 32'(o_cls[0]), 32'd5);
        cyc();

        // 6: start held high through a whole run gives exactly one done.
        dc0 = done_cnt[0];
        run(0, 1'b1, lat);
        repeat (20) cyc();
        chk("t6_done_count", 0, 32'(done_cnt[0] - dc0), 32'd1);

        // Reset in the middle of ARGMAX (T+790) clears every output on the next cycle.
        start_v[0] = 1'b1;
        cyc();
        start_v[0] = 1'b0;
        repeat (789) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("t6_rst_mac", 0, 32'(o_mac[0]), 32'd0);
        chk("t6_rst_pix", 0, o_pix[0], 32'd0);
        chk("t6_rst_class", 0, 32'(o_cls[0]), 32'd0);
        chk("t6_rst_score", 0, o_score[0], 32'd0);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
